led_blink_scheduler: RTL and testbench
======================================

LED_BLINK_SCHEDULER -- requirements
Module: led_blink_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 6_000_000, is the number of CLK cycles per blink phase (0.5 s at 12 MHz); legal values are >= 2.
REQ-002 Parameter NREQ is fixed at 3 and is the number of requesters sharing the LED.
REQ-003 Port CLK  input  1  is the single system clock (12 MHz on board); all state changes on its rising edge.
REQ-004 Port RST  input  1  is the asynchronous, active-high reset.
REQ-005 Port REQ  input  3  carries one request bit per requester, level-sensitive.
REQ-006 Port REQ_COUNT  input  12  holds packed 4-bit blink counts: requester i uses bits [4i+3:4i].
REQ-007 Port GRANT  output  3  is the one-hot owner of the LED; it is all-zero when idle.
REQ-008 Port DONE  output  3  pulses for one cycle, one-hot, in the final cycle of requester i's sequence.
REQ-009 Port LED  output  1  drives the shared LED, active-high.
REQ-010 Port BUSY  output  1  is high whenever the FSM is not in IDLE.

Function
REQ-011 All outputs SHALL be registered, with no combinational path from REQ or REQ_COUNT to any output.
REQ-012 All logic SHALL run on CLK only, with no derived or ripple clocks; phase timing SHALL come from an internal prescaler that counts 0..TICK_DIV-1.
REQ-013 The FSM SHALL have the states IDLE, ON, OFF, GAP and FIN.
REQ-014 IDLE: at the first edge with REQ != 0, the block SHALL select the winner round-robin, searching from LAST+1 mod 3 (then LAST+2, then LAST), and SHALL then:
- set GRANT to the winner and LAST to the winner index;
- latch REM = that requester's REQ_COUNT slice;
- clear the prescaler.
REQ-015 After the IDLE selection edge, if REM != 0 the next state SHALL be ON with LED=1; if REM == 0 the next state SHALL be FIN.
REQ-016 ON, OFF and GAP SHALL each last exactly TICK_DIV cycles, with the prescaler cleared on every phase transition.
REQ-017 ON: LED=1; on phase end the block SHALL go to OFF, set LED=0 and decrement REM.
REQ-018 OFF: LED=0; on phase end the block SHALL go to ON with LED=1 if REM != 0, otherwise to GAP.
REQ-019 GAP: LED=0, as a separator between owners; on phase end the block SHALL go to FIN.
REQ-020 FIN: lasts one cycle, with GRANT still held and DONE = GRANT; the next state SHALL be IDLE with GRANT=0 and DONE=0.
REQ-021 For a count n > 0, GRANT SHALL be high for exactly (2n+1)*TICK_DIV + 1 cycles; for n == 0, GRANT and DONE SHALL both be high for exactly one cycle and LED SHALL stay 0.
REQ-022 The schedule SHALL be non-preemptive: REQ and REQ_COUNT changes after the grant edge are ignored until FIN, and dropping REQ mid-sequence SHALL still complete the sequence and pulse DONE.
REQ-023 A requester still asserting REQ in FIN SHALL be re-arbitrated normally; the earliest new grant edge is the end of the IDLE cycle following FIN.
REQ-024 REM SHALL be 4 bits unsigned and never wrap: a decrement only occurs from REM >= 1.
REQ-025 GRANT SHALL never have more than one bit set, and LED SHALL be 0 whenever GRANT == 0.

Reset
REQ-026 While RST=1, asynchronously, the block SHALL force state=IDLE, GRANT=0, DONE=0, LED=0, BUSY=0, prescaler=0, REM=0 and LAST=2, so that requester 0 wins first after reset.
REQ-027 RST asserted mid-sequence SHALL abort it with no DONE pulse; the first edge after RST deasserts behaves as IDLE.

Verification (TICK_DIV=4)
REQ-028 REQ=001, count0=2 -> GRANT=001 for 21 cycles; LED pattern 1x4, 0x4, 1x4, 0x4, 0x4; DONE=001 in cycle 21 only.
REQ-029 REQ=111 held, all counts=1 -> grant order 001, 010, 100, 001, each 13 cycles with one idle cycle between grants.
REQ-030 REQ=010, count1=0 -> GRANT=010 and DONE=010 together for 1 cycle; LED stays 0; BUSY is high for 1 cycle.
REQ-031 RST pulsed during the second ON phase -> LED, GRANT and BUSY go to 0 immediately with no DONE; afterwards REQ=110 -> GRANT=010.
REQ-032 REQ=100 dropped 3 cycles after grant, count2=1 -> the sequence completes and DONE=100 is asserted 13 cycles after the grant edge.
REQ-033 count0=15 -> GRANT high for 125 cycles, 15 LED high pulses of 4 cycles each, and no REM underflow.

Source files
------------

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of one shared LED: each granted requester gets REM blinks
// (ON/OFF phases of TICK_DIV cycles), a dark GAP phase, then a one-cycle FIN with DONE.
module led_blink_scheduler #(
  parameter int TICK_DIV = 6_000_000,
  parameter int NREQ     = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [4*NREQ-1:0] REQ_COUNT,
  output logic [NREQ-1:0]   GRANT,
  output logic [NREQ-1:0]   DONE,
  output logic              LED,
  output logic              BUSY
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_END = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, ON, OFF, GAP, FIN} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pre, pre_nxt;
  logic [3:0]      rem, rem_nxt;
  logic [1:0]      last, last_nxt;
  logic [1:0]      c1, c2, win;
  logic [NREQ-1:0] grant_nxt, done_nxt;
  logic            led_nxt, busy_nxt;
  logic            phase_end;

  assign phase_end = (pre == PRE_END);

  // Search order LAST+1, LAST+2, LAST (mod 3); win is only used when REQ != 0.
  always_comb begin
    c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (REQ[c1])      win = c1;
    else if (REQ[c2]) win = c2;
    else              win = last;
  end

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    rem_nxt   = rem;
    last_nxt  = last;
    grant_nxt = GRANT;
    done_nxt  = '0;
    led_nxt   = LED;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        led_nxt   = 1'b0;
        if (|REQ) begin
          grant_nxt = NREQ'(1) << win;
          last_nxt  = win;
          rem_nxt   = REQ_COUNT[4*win +: 4];
          pre_nxt   = '0;
          if (REQ_COUNT[4*win +: 4] != 4'd0) begin
            state_nxt = ON;
            led_nxt   = 1'b1;
          end else begin
            state_nxt = FIN;
            done_nxt  = NREQ'(1) << win;
          end
        end
      end
      ON: begin
        pre_nxt = pre + 1'b1;
        if (phase_end) begin
          pre_nxt   = '0;
          state_nxt = OFF;
          led_nxt   = 1'b0;
          rem_nxt   = (rem != 4'd0) ? rem - 4'd1 : rem;
        end
      end
      OFF: begin
        pre_nxt = pre + 1'b1;
        if (phase_end) begin
          pre_nxt = '0;
          if (rem != 4'd0) begin
            state_nxt = ON;
            led_nxt   = 1'b1;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        pre_nxt = pre + 1'b1;
        if (phase_end) begin
          pre_nxt   = '0;
          state_nxt = FIN;
          done_nxt  = GRANT;
        end
      end
      FIN: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        led_nxt   = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        led_nxt   = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      pre   <= '0;
      rem   <= 4'd0;
      last  <= 2'd2;
      GRANT <= '0;
      DONE  <= '0;
      LED   <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nxt;
      pre   <= pre_nxt;
      rem   <= rem_nxt;
      last  <= last_nxt;
      GRANT <= grant_nxt;
      DONE  <= done_nxt;
      LED   <= led_nxt;
      BUSY  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler with TICK_DIV=4: directed scenarios plus randomized
// sequences, each checked cycle by cycle against a round-robin / blink-length model.
module tb_led_blink_scheduler;
  localparam int T = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  REQ;
  logic [11:0] REQ_COUNT;
  logic [2:0]  GRANT, DONE;
  logic        LED, BUSY;

  int checks = 0;
  int errors = 0;
  int last_m = 2;

  always #5 CLK = ~CLK;

  led_blink_scheduler #(.TICK_DIV(T), .NREQ(3)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_COUNT(REQ_COUNT),
    .GRANT(GRANT), .DONE(DONE), .LED(LED), .BUSY(BUSY)
  );

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after FIN.
  task automatic do_seq(input logic [2:0] r, input logic [11:0] cnts, input int drop_at,
                        input bit hold, input bit scramble);
    int win, n, len, idx;
    logic [2:0] oh;
    logic exp_led;
    win = -1;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last_m + k) % 3;
      if (win < 0 && r[c]) win = c;
    end
    if (win < 0) win = last_m;
    last_m = win;
    oh = 3'b001 << win;
    n = int'(cnts[4*win +: 4]);
    len = (n > 0) ? (2*n + 1)*T + 1 : 1;
    REQ = r;
    REQ_COUNT = cnts;
    @(posedge CLK);
    @(negedge CLK);
    for (int t = 1; t <= len; t++) begin
      idx = t - 1;
      exp_led = (n > 0) && (idx < 2*n*T) && (((idx / T) % 2) == 0);
      checks++;
      if (GRANT !== oh) begin errors++; $display("FAIL grant t=%0d got %b exp %b", t, GRANT, oh); end
      checks++;
      if (LED !== exp_led) begin errors++; $display("FAIL led t=%0d got %b exp %b", t, LED, exp_led); end
      checks++;
      if (DONE !== ((t == len) ? oh : 3'b000)) begin
        errors++; $display("FAIL done t=%0d got %b exp %b", t, DONE, (t == len) ? oh : 3'b000);
      end
      checks++;
      if (BUSY !== 1'b1) begin errors++; $display("FAIL busy t=%0d got %b exp 1", t, BUSY); end
      if (scramble && t == 2) begin
        REQ = 3'($urandom);
        REQ_COUNT = 12'($urandom);
      end
      if (t == drop_at) REQ = 3'b000;
      if (t == len) REQ = hold ? r : 3'b000;
      @(negedge CLK);
    end
    checks++;
    if (GRANT !== 3'b000) begin errors++; $display("FAIL idle_grant got %b exp 000", GRANT); end
    checks++;
    if (DONE !== 3'b000) begin errors++; $display("FAIL idle_done got %b exp 000", DONE); end
    checks++;
    if (LED !== 1'b0) begin errors++; $display("FAIL idle_led got %b exp 0", LED); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", BUSY); end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    REQ = 3'b111;
    REQ_COUNT = 12'h111;
    repeat (3) @(negedge CLK);
    checks++;
    if ({GRANT, DONE, LED, BUSY} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %b exp 00000000", {GRANT, DONE, LED, BUSY});
    end
    REQ = 3'b000;
    RST = 1'b0;
    last_m = 2;
    @(negedge CLK);
    checks++;
    if (GRANT !== 3'b000) begin errors++; $display("FAIL post_reset_idle got %b exp 000", GRANT); end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) do_seq(3'b111, 12'h111, 0, (i < 3), 1'b0);
  endtask

  task automatic test_single();
    do_seq(3'b001, 12'h002, 0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_count();
    do_seq(3'b010, 12'h000, 0, 1'b0, 1'b0);
  endtask

  task automatic test_drop();
    do_seq(3'b100, 12'h100, 3, 1'b0, 1'b0);
  endtask

  task automatic test_max_count();
    do_seq(3'b001, 12'h00F, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    REQ = 3'b001;
    REQ_COUNT = 12'h002;
    @(posedge CLK);
    repeat (10) @(negedge CLK);
    checks++;
    if (LED !== 1'b1) begin errors++; $display("FAIL mid_second_on_led got %b exp 1", LED); end
    #2 RST = 1'b1;
    REQ = 3'b000;
    #1;
    checks++;
    if ({GRANT, LED, BUSY, DONE} !== 8'h00) begin
      errors++; $display("FAIL mid_reset_async got %b exp 00000000", {GRANT, LED, BUSY, DONE});
    end
    @(negedge CLK);
    RST = 1'b0;
    last_m = 2;
    checks++;
    if (DONE !== 3'b000) begin errors++; $display("FAIL mid_reset_done got %b exp 000", DONE); end
    do_seq(3'b110, 12'h111, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [2:0]  r;
      logic [11:0] c;
      int drop;
      r = 3'($urandom_range(1, 7));
      c = {2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0;
      do_seq(r, c, drop, $urandom_range(0, 1) == 1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_count();
    test_drop();
    test_max_count();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
